// File: rtl/imm_gen_pipe_pkg.sv
// Purpose: shared types and opcode constants for the pipelined immediate generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imm_pkg;

    // Format code reported alongside every decoded immediate
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_SH   = 3'd6
    } fmt_e;

    // Base opcodes that carry an immediate
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // funct3 001 (SLLI) and 101 (SRLI/SRAI) are the shift encodings of OP-IMM
    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3[1:0] == 2'b01);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Purpose: groups the upstream and downstream valid/ready channels of imm_gen_pipe.
// Latency: n/a (wires only).
// Backpressure: in_ready_i/out_ready_i carry the usual valid/ready semantics.
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      in_inst_i;
    logic [TAG_W-1:0] in_tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  out_imm_o;
    fmt_e             out_fmt_o;
    logic [TAG_W-1:0] out_tag_o;

    // Producer/consumer side (fetch stage and ALU operand mux)
    modport master (
        output in_valid_i, in_inst_i, in_tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_imm_o, out_fmt_o, out_tag_o
    );

    // Immediate generator side
    modport slave (
        input  in_valid_i, in_inst_i, in_tag_i, out_ready_i,
        output in_ready_o, out_valid_o, out_imm_o, out_fmt_o, out_tag_o
    );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Purpose: combinational extraction and extension of the RV32I/RV64I immediate.
// Latency: zero cycles (pure logic).
// Backpressure: none; output follows input.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt
);
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [31:0] w_imm32;
    logic [5:0]  w_shamt;

    assign w_opc = i_inst[6:0];
    assign w_f3  = i_inst[14:12];

    // RV64 widens shamt to six bits; funct7 bits above it never leak into the immediate
    assign w_shamt = (XLEN == 64) ? i_inst[25:20] : {1'b0, i_inst[24:20]};

    // Classify the opcode and build a 32-bit sign-carrying immediate
    always_comb begin
        o_fmt   = FMT_NONE;
        w_imm32 = '0;
        case (w_opc)
            OPC_LOAD, OPC_JALR: begin
                o_fmt   = FMT_I;
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OPC_OPIMM: begin
                o_fmt   = is_shift_f3(w_f3) ? FMT_SH : FMT_I;
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            end
            OPC_OPIMM32: begin
                // Word ops only exist on RV64; on RV32 this opcode is illegal
                if (XLEN == 64) begin
                    o_fmt   = is_shift_f3(w_f3) ? FMT_SH : FMT_I;
                    w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
                end
            end
            OPC_STORE: begin
                o_fmt   = FMT_S;
                w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            end
            OPC_BRANCH: begin
                o_fmt   = FMT_B;
                w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                o_fmt   = FMT_U;
                w_imm32 = {i_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                o_fmt   = FMT_J;
                w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                           i_inst[20], i_inst[30:21], 1'b0};
            end
            default: begin
                o_fmt   = FMT_NONE;
                w_imm32 = '0;
            end
        endcase
    end

    // Shift amounts are zero-extended; everything else sign-extends to XLEN
    assign o_imm = (o_fmt == FMT_SH) ? XLEN'(w_shamt) : XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Purpose: registered immediate generator with a two-entry skid buffer on the output.
// Latency: one cycle from accepted word to out_valid_o with decoded immediate.
// Backpressure: holds up to two words; in_ready_o is a flop and drops the cycle after the second push.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int TAG_W = 8
) (
    input logic          clk_i,
    input logic          rst_i,
    imm_gen_pipe_if.slave bus
);
    logic [ILEN-1:0]  w_inst;
    logic [XLEN-1:0]  w_dec_imm;
    fmt_e             w_dec_fmt;
    logic             w_push;
    logic             w_pop;
    skid_state_e      w_next;
    logic             w_ld_out_in;
    logic             w_ld_out_skid;
    logic             w_ld_skid;

    skid_state_e      r_state;
    logic             r_in_rdy;
    logic             r_out_vld;
    logic [XLEN-1:0]  r_out_imm;
    fmt_e             r_out_fmt;
    logic [TAG_W-1:0] r_out_tag;
    logic [XLEN-1:0]  r_skid_imm;
    fmt_e             r_skid_fmt;
    logic [TAG_W-1:0] r_skid_tag;

    assign w_inst = bus.in_inst_i;

    // Decode on the input side so both buffer entries hold finished results
    imm_decode #(.XLEN(XLEN)) u_dec (
        .i_inst (w_inst[31:0]),
        .o_imm  (w_dec_imm),
        .o_fmt  (w_dec_fmt)
    );

    assign w_push = bus.in_valid_i & r_in_rdy;
    assign w_pop  = r_out_vld & bus.out_ready_i;

    // State register; ready/valid flops track the next state so neither is combinational
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= SKID_EMPTY;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_in_rdy  <= (w_next != SKID_TWO);
            r_out_vld <= (w_next != SKID_EMPTY);
        end
    end

    // Next-state logic for buffer occupancy
    always_comb begin
        w_next = r_state;
        case (r_state)
            SKID_EMPTY: if (w_push) w_next = SKID_ONE;
            SKID_ONE: begin
                if (w_push && !w_pop)      w_next = SKID_TWO;
                else if (!w_push && w_pop) w_next = SKID_EMPTY;
            end
            SKID_TWO:   if (w_pop) w_next = SKID_ONE;
            default:    w_next = SKID_EMPTY;
        endcase
    end

    // Datapath load enables derived from state and handshakes
    always_comb begin
        w_ld_out_in   = 1'b0;
        w_ld_out_skid = 1'b0;
        w_ld_skid     = 1'b0;
        case (r_state)
            SKID_EMPTY: w_ld_out_in = w_push;
            SKID_ONE: begin
                w_ld_out_in = w_push & w_pop;
                w_ld_skid   = w_push & ~w_pop;
            end
            SKID_TWO:   w_ld_out_skid = w_pop;
            default: begin
                w_ld_out_in   = 1'b0;
                w_ld_out_skid = 1'b0;
                w_ld_skid     = 1'b0;
            end
        endcase
    end

    // Output and skid payload registers; reset drops any buffered words
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_imm  <= '0;
            r_out_fmt  <= FMT_NONE;
            r_out_tag  <= '0;
            r_skid_imm <= '0;
            r_skid_fmt <= FMT_NONE;
            r_skid_tag <= '0;
        end else begin
            if (w_ld_out_in) begin
                r_out_imm <= w_dec_imm;
                r_out_fmt <= w_dec_fmt;
                r_out_tag <= bus.in_tag_i;
            end else if (w_ld_out_skid) begin
                r_out_imm <= r_skid_imm;
                r_out_fmt <= r_skid_fmt;
                r_out_tag <= r_skid_tag;
            end
            if (w_ld_skid) begin
                r_skid_imm <= w_dec_imm;
                r_skid_fmt <= w_dec_fmt;
                r_skid_tag <= bus.in_tag_i;
            end
        end
    end

    assign bus.in_ready_o  = r_in_rdy;
    assign bus.out_valid_o = r_out_vld;
    assign bus.out_imm_o   = r_out_imm;
    assign bus.out_fmt_o   = r_out_fmt;
    assign bus.out_tag_o   = r_out_tag;

endmodule
